// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the 3-byte UART command sender.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_CMD = 2'd1,
        SEND_HI  = 2'd2,
        SEND_LO  = 2'd3
    } snd_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_XMIT = 1'b1
    } tx_state_t;

    localparam int FRAME_BITS  = 10;
    localparam int FRAME_BYTES = 3;

endpackage
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : 8N1 UART bit transmitter; reloadable on the tx_done cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);

    tx_state_t   state_q, state_d;
    logic [9:0]  shift_q, shift_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        baud_term;

    assign baud_term = (baud_cnt_q == 16'(BAUD_DIV - 1));
    assign TX        = shift_q[0];

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_done    = 1'b0;

        if (state_q == TX_XMIT) begin
            if (baud_term) begin
                baud_cnt_d = 16'd0;
                if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                    tx_done   = 1'b1;
                    state_d   = TX_IDLE;
                    bit_cnt_d = 4'd0;
                end else begin
                    shift_d   = {1'b1, shift_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end else begin
                baud_cnt_d = baud_cnt_q + 16'd1;
            end
        end

        // A load takes priority so the next byte can start straight after a stop bit.
        if (trmt) begin
            state_d    = TX_XMIT;
            shift_d    = {1'b1, tx_data, 1'b0};
            baud_cnt_d = 16'd0;
            bit_cnt_d  = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            shift_q    <= '1;
            baud_cnt_q <= 16'd0;
            bit_cnt_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_sender.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_sender
//  Description : Sends {cmd, data[15:8], data[7:0]} as three back-to-back 8N1 frames.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_cmd_sender
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        snd_cmd,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    output logic        busy,
    output logic        cmd_sent,
    output logic        TX
);

    snd_state_t  state_q, state_d;
    logic [15:0] data_q, data_d;
    logic        busy_q, busy_d;
    logic        cmd_sent_q, cmd_sent_d;
    logic        trmt;
    logic [7:0]  tx_byte;
    logic        tx_done;

    uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx (
        .clk     (clk),
        .rst     (rst),
        .trmt    (trmt),
        .tx_data (tx_byte),
        .TX      (TX),
        .tx_done (tx_done)
    );

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        busy_d     = busy_q;
        cmd_sent_d = cmd_sent_q;
        trmt       = 1'b0;
        tx_byte    = 8'hFF;

        case (state_q)
            IDLE: begin
                // cmd goes straight to the transmitter, so only data needs a shadow copy.
                tx_byte = cmd;
                if (snd_cmd) begin
                    trmt       = 1'b1;
                    data_d     = data;
                    busy_d     = 1'b1;
                    cmd_sent_d = 1'b0;
                    state_d    = SEND_CMD;
                end
            end
            SEND_CMD: begin
                tx_byte = data_q[15:8];
                if (tx_done) begin
                    trmt    = 1'b1;
                    state_d = SEND_HI;
                end
            end
            SEND_HI: begin
                tx_byte = data_q[7:0];
                if (tx_done) begin
                    trmt    = 1'b1;
                    state_d = SEND_LO;
                end
            end
            SEND_LO: begin
                if (tx_done) begin
                    busy_d     = 1'b0;
                    cmd_sent_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= 16'd0;
            busy_q     <= 1'b0;
            cmd_sent_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            cmd_sent_q <= cmd_sent_d;
        end
    end

    assign busy     = busy_q;
    assign cmd_sent = cmd_sent_q;

endmodule
`default_nettype wire
